// File: rtl/axi_lite_reg_bank.sv
// rtl/axi_lite_reg_bank.sv - register bank behind the AXI-Lite slave user interface
// Optional cycle counter at 0x18 is built only when REG_BANK_COUNTER_EN is defined.
module axi_lite_reg_bank #(
  parameter int          ADDR_WIDTH    = 16,
  parameter int          IRQ_WIDTH     = 8,
  parameter logic [31:0] VERSION       = 32'h00010000,
  parameter logic [31:0] CONTROL_RESET = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_reg_in_rdy,
  output logic                  o_reg_in_ack_stb,
  input  logic [ADDR_WIDTH-1:0] i_reg_address,
  input  logic [31:0]           i_reg_in_data,
  input  logic                  i_reg_out_req,
  output logic                  o_reg_out_rdy_stb,
  output logic [31:0]           o_reg_out_data,
  output logic                  o_reg_invalid_addr,
  output logic [31:0]           o_control,
  input  logic [31:0]           i_status,
  input  logic [IRQ_WIDTH-1:0]  i_irq_src,
  output logic                  o_irq
);

  localparam int WW = ADDR_WIDTH - 2;

  logic [WW-1:0]        w_word;
  logic                 w_wr_go;
  logic                 w_rd_go;
  logic                 w_invalid;
  logic [31:0]          w_rd_data;
  logic [IRQ_WIDTH-1:0] w_irq_set;
  logic [IRQ_WIDTH-1:0] w_irq_clr;
  logic                 w_unused_addr_lo;

  logic                 r_wr_busy;
  logic                 r_rd_busy;
  logic                 r_wr_ack;
  logic                 r_rd_stb;
  logic [31:0]          r_rd_data;
  logic                 r_invalid;
  logic [31:0]          r_control;
  logic [31:0]          r_scratch;
  logic [IRQ_WIDTH-1:0] r_irq_en;
  logic [IRQ_WIDTH-1:0] r_irq_st;
  logic [IRQ_WIDTH-1:0] r_src_d;
  logic                 r_irq;

  // Byte lanes are ignored; registers are word addressed.
  assign w_word           = i_reg_address[ADDR_WIDTH-1:2];
  assign w_unused_addr_lo = ^i_reg_address[1:0];

  // A write always wins a tie; the read then goes the cycle after the write ack.
  assign w_wr_go = i_reg_in_rdy & ~r_wr_busy;
  assign w_rd_go = i_reg_out_req & ~r_rd_busy & ~w_wr_go;

  // New edge on a source sets its bit; a W1C in the same cycle cannot hide it.
  assign w_irq_set = i_irq_src & ~r_src_d;
  assign w_irq_clr = (w_wr_go && w_word == WW'(3)) ? i_reg_in_data[IRQ_WIDTH-1:0] : '0;

`ifdef REG_BANK_COUNTER_EN
  logic [31:0] r_counter;

  // Free-running cycle counter; any committed write to it clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_counter <= 32'h0;
    end else if (w_wr_go && w_word == WW'(6)) begin
      r_counter <= 32'h0;
    end else begin
      r_counter <= r_counter + 32'h1;
    end
  end
`endif

  // Address decode and read-data mux.
  always_comb begin
    w_invalid = 1'b0;
    w_rd_data = 32'h0;
    case (w_word)
      WW'(0): w_rd_data = r_control;
      WW'(1): w_rd_data = i_status;
      WW'(2): w_rd_data = 32'(r_irq_en);
      WW'(3): w_rd_data = 32'(r_irq_st);
      WW'(4): w_rd_data = r_scratch;
      WW'(5): w_rd_data = VERSION;
`ifdef REG_BANK_COUNTER_EN
      WW'(6): w_rd_data = r_counter;
`endif
      default: w_invalid = 1'b1;
    endcase
  end

  // Write handshake and register commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_busy <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_control <= CONTROL_RESET;
      r_scratch <= 32'h0;
      r_irq_en  <= '0;
    end else begin
      r_wr_ack <= w_wr_go;
      if (w_wr_go) begin
        r_wr_busy <= 1'b1;
      end else if (!i_reg_in_rdy) begin
        r_wr_busy <= 1'b0;
      end
      if (w_wr_go) begin
        case (w_word)
          WW'(0):  r_control <= i_reg_in_data;
          WW'(2):  r_irq_en  <= i_reg_in_data[IRQ_WIDTH-1:0];
          WW'(4):  r_scratch <= i_reg_in_data;
          default: ;
        endcase
      end
    end
  end

  // Read handshake; data and invalid flag registered alongside the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_busy <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_rd_data <= 32'h0;
      r_invalid <= 1'b0;
    end else begin
      r_rd_stb  <= w_rd_go;
      r_invalid <= (w_wr_go | w_rd_go) & w_invalid;
      if (w_rd_go) begin
        r_rd_data <= w_rd_data;
        r_rd_busy <= 1'b1;
      end else if (!i_reg_out_req) begin
        r_rd_busy <= 1'b0;
      end
    end
  end

  // Interrupt edge capture, status with W1C, and registered level output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_d  <= '0;
      r_irq_st <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_src_d  <= i_irq_src;
      r_irq_st <= (r_irq_st & ~w_irq_clr) | w_irq_set;
      r_irq    <= |(r_irq_st & r_irq_en);
    end
  end

  assign o_reg_in_ack_stb   = r_wr_ack;
  assign o_reg_out_rdy_stb  = r_rd_stb;
  assign o_reg_out_data     = r_rd_data;
  assign o_reg_invalid_addr = r_invalid;
  assign o_control          = r_control;
  assign o_irq              = r_irq;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// tb/tb_axi_lite_reg_bank.sv - scoreboard bench for axi_lite_reg_bank
module tb_axi_lite_reg_bank;

  localparam int          AW   = 16;
  localparam int          IW   = 8;
  localparam logic [31:0] VER  = 32'h00010000;
  localparam logic [31:0] CRST = 32'h0;
`ifdef REG_BANK_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_reg_in_rdy = 1'b0;
  logic          o_reg_in_ack_stb;
  logic [AW-1:0] i_reg_address = '0;
  logic [31:0]   i_reg_in_data = '0;
  logic          i_reg_out_req = 1'b0;
  logic          o_reg_out_rdy_stb;
  logic [31:0]   o_reg_out_data;
  logic          o_reg_invalid_addr;
  logic [31:0]   o_control;
  logic [31:0]   i_status = '0;
  logic [IW-1:0] i_irq_src = '0;
  logic          o_irq;

  axi_lite_reg_bank #(
    .ADDR_WIDTH(AW), .IRQ_WIDTH(IW), .VERSION(VER), .CONTROL_RESET(CRST)
  ) dut (
    .clk(clk), .rst(rst),
    .i_reg_in_rdy(i_reg_in_rdy), .o_reg_in_ack_stb(o_reg_in_ack_stb),
    .i_reg_address(i_reg_address), .i_reg_in_data(i_reg_in_data),
    .i_reg_out_req(i_reg_out_req), .o_reg_out_rdy_stb(o_reg_out_rdy_stb),
    .o_reg_out_data(o_reg_out_data), .o_reg_invalid_addr(o_reg_invalid_addr),
    .o_control(o_control), .i_status(i_status),
    .i_irq_src(i_irq_src), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        inv;
    bit          chk_data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic    wr_q[$];
  int      checks   = 0;
  int      failures = 0;

  logic [31:0] m_ctrl;
  logic [31:0] m_scratch;
  logic [IW-1:0] m_en;
  logic [IW-1:0] m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_mapped(input logic [AW-1:0] a);
    int w;
    w = int'(a >> 2);
    return (w <= 5) || (CNT_EN && w == 6);
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a, input logic [31:0] st);
    case (int'(a >> 2))
      0: return m_ctrl;
      1: return st;
      2: return 32'(m_en);
      3: return 32'(m_st);
      4: return m_scratch;
      5: return VER;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [IW-1:0] pulse);
    logic [IW-1:0] clr;
    clr = '0;
    case (int'(a >> 2))
      0: m_ctrl = d;
      2: m_en = d[IW-1:0];
      3: clr = d[IW-1:0];
      4: m_scratch = d;
      default: ;
    endcase
    m_st = (m_st & ~clr) | pulse;
  endtask

  task automatic m_reset();
    m_ctrl = CRST; m_scratch = 0; m_en = 0; m_st = 0;
  endtask

  // Scoreboard monitor: pops an expectation for every strobe the DUT presents.
  always @(negedge clk) begin
    if (o_reg_in_ack_stb === 1'b1) begin
      if (wr_q.size() == 0) chk("unexpected_ack", 32'(o_reg_in_ack_stb), 32'h0);
      else chk("wr_invalid", 32'(o_reg_invalid_addr), 32'(wr_q.pop_front()));
    end
    if (o_reg_out_rdy_stb === 1'b1) begin
      if (rd_q.size() == 0) chk("unexpected_rd_stb", 32'(o_reg_out_rdy_stb), 32'h0);
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rd_invalid", 32'(o_reg_invalid_addr), 32'(e.inv));
        if (e.chk_data) chk("rd_data", o_reg_out_data, e.data);
      end
    end
    if (o_reg_in_ack_stb === 1'b1 && o_reg_out_rdy_stb === 1'b1)
      chk("both_strobes", 32'h1, 32'h0);
    if (o_reg_in_ack_stb !== 1'b1 && o_reg_out_rdy_stb !== 1'b1 && !rst)
      chk("invalid_idle", 32'(o_reg_invalid_addr), 32'h0);
  end

  task automatic wr_start(input logic [AW-1:0] a, input logic [31:0] d, input logic [IW-1:0] pulse);
    int n;
    @(posedge clk); #1;
    i_reg_address = a; i_reg_in_data = d; i_reg_in_rdy = 1'b1; i_irq_src = pulse;
    wr_q.push_back(!m_mapped(a));
    m_write(a, d, pulse);
    n = 0;
    do begin @(negedge clk); n++; end while (o_reg_in_ack_stb !== 1'b1 && n < 8);
    chk("wr_latency", 32'(n), 32'd2);
  endtask

  task automatic wr_end(input int hold);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    i_reg_in_rdy = 1'b0; i_irq_src = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input int hold);
    wr_start(a, d, '0);
    wr_end(hold);
    chk("o_control", o_control, m_ctrl);
  endtask

  task automatic rd_start(input logic [AW-1:0] a, input bit chk_data);
    rd_exp_t e;
    int n;
    @(posedge clk); #1;
    i_reg_address = a; i_status = $urandom; i_reg_out_req = 1'b1;
    e.data = m_read(a, i_status); e.inv = !m_mapped(a); e.chk_data = chk_data;
    rd_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (o_reg_out_rdy_stb !== 1'b1 && n < 8);
    chk("rd_latency", 32'(n), 32'd2);
  endtask

  task automatic rd_end(input int hold);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    i_reg_out_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd_start(a, 1'b1);
    rd_end(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_exp_t e;
    logic [AW-1:0] a;
    m_reset();
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(o_reg_in_ack_stb), 32'h0);
    chk("rst_rd_stb", 32'(o_reg_out_rdy_stb), 32'h0);
    chk("rst_data", o_reg_out_data, 32'h0);
    chk("rst_invalid", 32'(o_reg_invalid_addr), 32'h0);
    chk("rst_control", o_control, CRST);
    chk("rst_irq", 32'(o_irq), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic write/readback of SCRATCH
    do_write(16'h0010, 32'hDEADBEEF, 0);
    do_read(16'h0010);

    // Held rdy: single ack, then a second rise gives a second ack
    do_write(16'h0000, 32'h0000_00A5, 5);
    do_write(16'h0000, 32'h0000_005A, 0);
    do_read(16'h0000);

    // Unmapped addresses and VERSION
    do_read(16'h0040);
    do_write(16'h0040, 32'hFFFF_FFFF, 0);
    do_read(16'h0014);
    do_write(16'h0014, 32'h1234_5678, 0);
    do_read(16'h0014);
    do_read(16'h0004);
    do_read(16'h0013);

    // Simultaneous write and read: write first, read the cycle after
    begin
      @(posedge clk); #1;
      i_reg_address = 16'h0010; i_reg_in_data = 32'hCAFE_F00D;
      i_reg_in_rdy = 1'b1; i_reg_out_req = 1'b1;
      wr_q.push_back(1'b0);
      m_write(16'h0010, 32'hCAFE_F00D, '0);
      e.data = 32'hCAFE_F00D; e.inv = 1'b0; e.chk_data = 1'b1;
      rd_q.push_back(e);
      @(negedge clk);
      chk("prio_idle_ack", 32'(o_reg_in_ack_stb), 32'h0);
      @(negedge clk);
      chk("prio_wr_ack", 32'(o_reg_in_ack_stb), 32'h1);
      chk("prio_rd_wait", 32'(o_reg_out_rdy_stb), 32'h0);
      @(negedge clk);
      chk("prio_rd_stb", 32'(o_reg_out_rdy_stb), 32'h1);
      @(posedge clk); #1;
      i_reg_in_rdy = 1'b0; i_reg_out_req = 1'b0;
    end

    // IRQ: enable bit 0, pulse the source
    do_write(16'h0008, 32'hFFFF_FF01, 0);
    do_read(16'h0008);
    @(posedge clk); #1 i_irq_src = 8'h01; m_st = m_st | 8'h01;
    @(posedge clk); #1 i_irq_src = 8'h00;
    repeat (2) @(negedge clk);
    chk("irq_set", 32'(o_irq), 32'h1);
    do_read(16'h000C);
    // W1C together with a new edge: the set wins
    wr_start(16'h000C, 32'h1, 8'h01);
    wr_end(0);
    do_read(16'h000C);
    chk("irq_set_wins", 32'(o_irq), 32'h1);
    // Masked source sets status but not the interrupt
    @(posedge clk); #1 i_irq_src = 8'h02; m_st = m_st | 8'h02;
    @(posedge clk); #1 i_irq_src = 8'h00;
    // W1C alone: o_irq drops one cycle after the clear
    wr_start(16'h000C, 32'h1, 8'h00);
    chk("irq_lag", 32'(o_irq), 32'h1);
    @(negedge clk);
    chk("irq_clear", 32'(o_irq), 32'h0);
    wr_end(0);
    do_read(16'h000C);
    repeat (2) @(negedge clk);
    chk("irq_masked", 32'(o_irq), 32'h0);

    // Reset in the middle of a write handshake
    @(posedge clk); #1;
    i_reg_address = 16'h0010; i_reg_in_data = 32'h1234_5678;
    i_reg_in_rdy = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_ack", 32'(o_reg_in_ack_stb), 32'h0);
    chk("rst_mid_control", o_control, CRST);
    chk("rst_mid_irq", 32'(o_irq), 32'h0);
    @(posedge clk); #1 i_reg_in_rdy = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    m_reset();
    do_read(16'h0010);
    do_read(16'h000C);
    do_read(16'h0008);

    // Counter region
`ifdef REG_BANK_COUNTER_EN
    repeat (20) @(posedge clk);
    do_write(16'h0018, 32'hFFFF_FFFF, 0);
    rd_start(16'h0018, 1'b0);
    chk("counter_small", 32'(o_reg_out_data < 32'd16), 32'h1);
    rd_end(0);
`else
    do_read(16'h0018);
    do_write(16'h0018, 32'h1, 0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      int pick;
      bit is_rd;
      pick = $urandom_range(0, 9);
      if (pick <= 7) a = AW'(pick * 4 + $urandom_range(0, 3));
      else if (pick == 8) a = 16'h0040;
      else a = AW'($urandom);
      is_rd = $urandom_range(0, 1) == 1;
      if (is_rd && CNT_EN && (a >> 2) == 6) is_rd = 1'b0;
      if (is_rd) begin
        rd_start(a, 1'b1);
        rd_end($urandom_range(0, 2));
      end else begin
        do_write(a, $urandom, $urandom_range(0, 2));
      end
    end

    // Drain
    for (int i = 0; i < 10 && (wr_q.size() != 0 || rd_q.size() != 0); i++) @(negedge clk);
    chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
